// File: rtl/calc_key_sequencer_pkg.sv
// calc_pkg: shared definitions for the calculator key sequencer.
//   - keypad code constants (digits 0-9, clear, operators, equals, memory keys)
//   - FSM state encoding (also driven out on the debug "state" port)
//   - register source-select encodings for A/B and M
// No ports; imported by calc_key_class and calc_key_sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_CLR  = 4'hA;
    localparam logic [3:0] KEY_ADD  = 4'hB;
    localparam logic [3:0] KEY_SUB  = 4'hC;
    localparam logic [3:0] KEY_EQ   = 4'hD;
    localparam logic [3:0] KEY_GETM = 4'hE;
    localparam logic [3:0] KEY_SETM = 4'hF;

    // Gray-ordered so the debug display only flips one bit per normal step.
    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_OP  = 2'b01,
        S_B   = 2'b11,
        S_RES = 2'b10
    } calc_state_t;

    // A/B source selects
    localparam logic [1:0] ESC_M     = 2'b00;
    localparam logic [1:0] ESC_SHIFT = 2'b01;
    localparam logic [1:0] ESC_ALU   = 2'b10;
    localparam logic [1:0] ESC_DIGIT = 2'b11;

    // M source selects
    localparam logic M_SRC_A = 1'b0;
    localparam logic M_SRC_B = 1'b1;

endpackage

// File: rtl/calc_key_sequencer_key_class.sv
// calc_key_class: combinational decode of a 4-bit keypad code into key classes.
// Ports:
//   key_code  in  4  raw keypad code
//   is_digit  out 1  0-9
//   is_op     out 1  '+' or '-'
//   is_eq     out 1  '='
//   is_clr    out 1  clear
//   is_getm   out 1  '#' recall memory
//   is_setm   out 1  '*' store memory
module calc_key_class
    import calc_pkg::*;
(
    input  logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr,
    output logic       is_getm,
    output logic       is_setm
);

    always_comb begin
        is_digit = (key_code <= KEY_9);
        is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
        is_eq    = (key_code == KEY_EQ);
        is_clr   = (key_code == KEY_CLR);
        is_getm  = (key_code == KEY_GETM);
        is_setm  = (key_code == KEY_SETM);
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: main calculator control FSM. Turns debounced key strobes
// into single-cycle load pulses and source selects for the A/B/M registers and
// the ALU add/sub select. All outputs are registered (one cycle after the strobe).
//
// Build option: define CALC_CHAIN_OPS_EN to let '+'/'-' typed while entering B
// fold the pending operation into A and start the next one (1+2+3...). Without
// it those keys are ignored in S_B.
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  async reset, active low
//   key_valid  in   1  key_code valid strobe
//   key_code   in   4  keypad code (see calc_pkg)
//   ld_a/ld_b/ld_m out 1  register load pulses
//   esc_a/esc_b out 2 A/B source select
//   m_src      out  1  M source select (A or B)
//   op_sub     out  1  ALU select, 1 = subtract
//   digit      out  4  digit value for the datapath
//   disp_sel   out  1  display B when high
//   state      out  2  current FSM state
//
// state | meaning
// ------+-------------------------------------------
// S_A   | entering first operand into A
// S_OP  | operator latched, waiting for first B digit
// S_B   | entering second operand into B
// S_RES | result in A; '=' repeats the last op
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       ld_a,
    output logic [1:0] esc_a,
    output logic       ld_b,
    output logic [1:0] esc_b,
    output logic       ld_m,
    output logic       m_src,
    output logic       op_sub,
    output logic [3:0] digit,
    output logic       disp_sel,
    output logic [1:0] state
);

    localparam int             CW      = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    calc_state_t   state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          op_nxt;
    // A chained operator must not reach op_sub until the ALU load using the
    // old op has been taken, so it is parked here for one cycle.
    logic          pend_q, pend_nxt;
    logic          pend_val_q, pend_val_nxt;

    logic       ld_a_nxt, ld_b_nxt, ld_m_nxt, m_src_nxt;
    logic [1:0] esc_a_nxt, esc_b_nxt;
    logic [3:0] digit_nxt;

    logic is_digit, is_op, is_eq, is_clr, is_getm, is_setm;
    logic key_sub;

    calc_key_class u_key_class (
        .key_code (key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr),
        .is_getm  (is_getm),
        .is_setm  (is_setm)
    );

    assign key_sub = (key_code == KEY_SUB);
    assign state   = state_q;

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        op_nxt       = pend_q ? pend_val_q : op_sub;
        pend_nxt     = 1'b0;
        pend_val_nxt = pend_val_q;
        ld_a_nxt     = 1'b0;
        ld_b_nxt     = 1'b0;
        ld_m_nxt     = 1'b0;
        esc_a_nxt    = esc_a;
        esc_b_nxt    = esc_b;
        m_src_nxt    = m_src;
        digit_nxt    = digit;

        if (key_valid) begin
            if (is_clr) begin
                ld_a_nxt  = 1'b1;
                ld_b_nxt  = 1'b1;
                esc_a_nxt = ESC_DIGIT;
                esc_b_nxt = ESC_DIGIT;
                digit_nxt = 4'h0;
                op_nxt    = 1'b0;
                cnt_nxt   = '0;
                state_nxt = S_A;
            end else begin
                case (state_q)
                    S_A: begin
                        if (is_digit) begin
                            if (cnt_q < CNT_MAX) begin
                                ld_a_nxt  = 1'b1;
                                esc_a_nxt = ESC_SHIFT;
                                digit_nxt = key_code;
                                cnt_nxt   = cnt_q + CNT_ONE;
                            end
                        end else if (is_op) begin
                            op_nxt    = key_sub;
                            cnt_nxt   = '0;
                            state_nxt = S_OP;
                        end else if (is_getm) begin
                            ld_a_nxt  = 1'b1;
                            esc_a_nxt = ESC_M;
                            cnt_nxt   = CNT_MAX;
                        end else if (is_setm) begin
                            ld_m_nxt  = 1'b1;
                            m_src_nxt = M_SRC_A;
                        end
                    end
                    S_OP: begin
                        if (is_digit) begin
                            ld_b_nxt  = 1'b1;
                            esc_b_nxt = ESC_DIGIT;
                            digit_nxt = key_code;
                            cnt_nxt   = CNT_ONE;
                            state_nxt = S_B;
                        end else if (is_op) begin
                            op_nxt = key_sub;
                        end else if (is_getm) begin
                            ld_b_nxt  = 1'b1;
                            esc_b_nxt = ESC_M;
                            cnt_nxt   = CNT_MAX;
                            state_nxt = S_B;
                        end else if (is_setm) begin
                            ld_m_nxt  = 1'b1;
                            m_src_nxt = M_SRC_A;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (cnt_q < CNT_MAX) begin
                                ld_b_nxt  = 1'b1;
                                esc_b_nxt = ESC_SHIFT;
                                digit_nxt = key_code;
                                cnt_nxt   = cnt_q + CNT_ONE;
                            end
                        end else if (is_eq) begin
                            ld_a_nxt  = 1'b1;
                            esc_a_nxt = ESC_ALU;
                            state_nxt = S_RES;
                        end else if (is_getm) begin
                            ld_b_nxt  = 1'b1;
                            esc_b_nxt = ESC_M;
                            cnt_nxt   = CNT_MAX;
                        end else if (is_setm) begin
                            ld_m_nxt  = 1'b1;
                            m_src_nxt = M_SRC_B;
                        end else if (is_op) begin
`ifdef CALC_CHAIN_OPS_EN
                            ld_a_nxt     = 1'b1;
                            esc_a_nxt    = ESC_ALU;
                            pend_nxt     = 1'b1;
                            pend_val_nxt = key_sub;
                            cnt_nxt      = '0;
                            state_nxt    = S_OP;
`else
                            state_nxt = S_B;
`endif
                        end
                    end
                    S_RES: begin
                        if (is_digit) begin
                            ld_a_nxt  = 1'b1;
                            esc_a_nxt = ESC_DIGIT;
                            digit_nxt = key_code;
                            cnt_nxt   = CNT_ONE;
                            state_nxt = S_A;
                        end else if (is_op) begin
                            op_nxt    = key_sub;
                            cnt_nxt   = '0;
                            state_nxt = S_OP;
                        end else if (is_eq) begin
                            ld_a_nxt  = 1'b1;
                            esc_a_nxt = ESC_ALU;
                        end else if (is_getm) begin
                            ld_a_nxt  = 1'b1;
                            esc_a_nxt = ESC_M;
                            cnt_nxt   = CNT_MAX;
                            state_nxt = S_A;
                        end else if (is_setm) begin
                            ld_m_nxt  = 1'b1;
                            m_src_nxt = M_SRC_A;
                        end
                    end
                    default: state_nxt = S_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            cnt_q      <= '0;
            op_sub     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= 1'b0;
            ld_a       <= 1'b0;
            ld_b       <= 1'b0;
            ld_m       <= 1'b0;
            esc_a      <= ESC_M;
            esc_b      <= ESC_M;
            m_src      <= M_SRC_A;
            digit      <= 4'h0;
            disp_sel   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            op_sub     <= op_nxt;
            pend_q     <= pend_nxt;
            pend_val_q <= pend_val_nxt;
            ld_a       <= ld_a_nxt;
            ld_b       <= ld_b_nxt;
            ld_m       <= ld_m_nxt;
            esc_a      <= esc_a_nxt;
            esc_b      <= esc_b_nxt;
            m_src      <= m_src_nxt;
            digit      <= digit_nxt;
            disp_sel   <= (state_nxt == S_B);
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       ld_a, ld_b, ld_m, m_src, op_sub, disp_sel;
    logic [1:0] esc_a, esc_b, state;
    logic [3:0] digit;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       ld_a;
        logic [1:0] esc_a;
        logic       ld_b;
        logic [1:0] esc_b;
        logic       ld_m;
        logic       m_src;
        logic       op_sub;
        logic [3:0] digit;
    } ev_t;

    typedef struct {
        ev_t ev;
        bit  dchk;
    } exp_t;

    ev_t  obs_q[$];
    exp_t exp_q[$];

    calc_key_sequencer #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .ld_a      (ld_a),
        .esc_a     (esc_a),
        .ld_b      (ld_b),
        .esc_b     (esc_b),
        .ld_m      (ld_m),
        .m_src     (m_src),
        .op_sub    (op_sub),
        .digit     (digit),
        .disp_sel  (disp_sel),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Record every cycle that carries a load pulse.
    always @(negedge clk) begin
        if (rst_n && (ld_a || ld_b || ld_m))
            obs_q.push_back(ev_t'{ld_a, esc_a, ld_b, esc_b, ld_m, m_src, op_sub, digit});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drop fields that are don't-care for the given event.
    function automatic ev_t norm(ev_t e, bit dchk);
        if (!e.ld_a) e.esc_a = 2'b00;
        if (!e.ld_b) e.esc_b = 2'b00;
        if (!e.ld_m) e.m_src = 1'b0;
        if (!dchk)   e.digit = 4'h0;
        return e;
    endfunction

    task automatic exp_push(input logic la, input logic [1:0] ea, input logic lb,
                            input logic [1:0] eb, input logic lm, input logic ms,
                            input logic os, input logic [3:0] d, input bit dc);
        exp_t x;
        x.ev   = ev_t'{la, ea, lb, eb, lm, ms, os, d};
        x.dchk = dc;
        exp_q.push_back(x);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if ({ld_a, esc_a, ld_b, esc_b, ld_m, m_src, op_sub, digit, disp_sel, state} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ld_a, esc_a, ld_b, esc_b, ld_m, m_src, op_sub, digit, disp_sel, state});
        end
        idle(3);
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("FAIL reset_idle_pulses: got %0d required 0", obs_q.size());
        end
    endtask

    task automatic test_basic();
        reset_dut();
        press(4'h1); exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h1, 1);
        press(4'h2); exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h2, 1);
        press(4'hB);
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL basic_state_op: got %b required 01", state);
        end
        press(4'h3); exp_push(0, 2'b00, 1, 2'b11, 0, 0, 0, 4'h3, 1);
        total++;
        if ({state, disp_sel} !== 3'b111) begin
            bad++; $display("FAIL basic_state_b: got %b required 111", {state, disp_sel});
        end
        press(4'hD); exp_push(1, 2'b10, 0, 2'b00, 0, 0, 0, 4'h0, 0);
        idle(2);
        total++;
        if ({state, disp_sel} !== 3'b100) begin
            bad++; $display("FAIL basic_state_res: got %b required 100", {state, disp_sel});
        end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL basic_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL basic_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_digit_limit();
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            press(4'(i));
            if (i <= 4) exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'(i), 1);
        end
        idle(2);
        total++;
        if (state !== 2'b00) begin
            bad++; $display("FAIL limit_state: got %b required 00", state);
        end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL limit_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL limit_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_repeat_eq();
        reset_dut();
        press(4'h5); exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h5, 1);
        press(4'hC);
        press(4'h2); exp_push(0, 2'b00, 1, 2'b11, 0, 0, 1, 4'h2, 1);
        press(4'hD); exp_push(1, 2'b10, 0, 2'b00, 0, 0, 1, 4'h0, 0);
        press(4'hD); exp_push(1, 2'b10, 0, 2'b00, 0, 0, 1, 4'h0, 0);
        total++;
        if (state !== 2'b10) begin
            bad++; $display("FAIL repeat_state: got %b required 10", state);
        end
        press(4'h9); exp_push(1, 2'b11, 0, 2'b00, 0, 0, 1, 4'h9, 1);
        idle(2);
        total++;
        if (state !== 2'b00) begin
            bad++; $display("FAIL repeat_newcalc_state: got %b required 00", state);
        end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL repeat_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL repeat_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_memory();
        reset_dut();
        press(4'h7); exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h7, 1);
        press(4'hF); exp_push(0, 2'b00, 0, 2'b00, 1, 0, 0, 4'h0, 0);
        press(4'hA); exp_push(1, 2'b11, 1, 2'b11, 0, 0, 0, 4'h0, 1);
        press(4'hE); exp_push(1, 2'b00, 0, 2'b00, 0, 0, 0, 4'h0, 0);
        press(4'h3);
        // M from B while entering B, then '#' in S_OP saturates the count
        press(4'hB);
        press(4'h4); exp_push(0, 2'b00, 1, 2'b11, 0, 0, 0, 4'h4, 1);
        press(4'hF); exp_push(0, 2'b00, 0, 2'b00, 1, 1, 0, 4'h0, 0);
        press(4'hA); exp_push(1, 2'b11, 1, 2'b11, 0, 0, 0, 4'h0, 1);
        press(4'hB);
        press(4'hE); exp_push(0, 2'b00, 1, 2'b00, 0, 0, 0, 4'h0, 0);
        press(4'h6);
        idle(2);
        total++;
        if (state !== 2'b11) begin
            bad++; $display("FAIL memory_state: got %b required 11", state);
        end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL memory_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL memory_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_chain();
        reset_dut();
        press(4'h1); exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h1, 1);
        press(4'hB);
        press(4'h2); exp_push(0, 2'b00, 1, 2'b11, 0, 0, 0, 4'h2, 1);
        press(4'hC);
`ifdef CALC_CHAIN_OPS_EN
        exp_push(1, 2'b10, 0, 2'b00, 0, 0, 0, 4'h0, 0);
        idle(2);
        total++;
        if ({state, op_sub} !== 3'b011) begin
            bad++; $display("FAIL chain_state_op: got %b required 011", {state, op_sub});
        end
`else
        idle(2);
        total++;
        if ({state, op_sub} !== 3'b110) begin
            bad++; $display("FAIL chain_state_op: got %b required 110", {state, op_sub});
        end
`endif
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL chain_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL chain_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] keys [5];
        keys = '{4'h1, 4'h2, 4'hB, 4'h4, 4'h5};
        reset_dut();
        exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h1, 1);
        exp_push(1, 2'b01, 0, 2'b00, 0, 0, 0, 4'h2, 1);
        exp_push(0, 2'b00, 1, 2'b11, 0, 0, 0, 4'h4, 1);
        exp_push(0, 2'b00, 1, 2'b01, 0, 0, 0, 4'h5, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_code  = keys[i];
        end
        @(negedge clk);
        key_valid = 1'b0;
        idle(2);
        total++;
        if (state !== 2'b11) begin
            bad++; $display("FAIL b2b_state: got %b required 11", state);
        end
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            ev_t  o = obs_q.pop_front();
            total++;
            if (norm(o, e.dchk) !== norm(e.ev, e.dchk)) begin
                bad++; $display("FAIL b2b_event: got %h required %h", norm(o, e.dchk), norm(e.ev, e.dchk));
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        press(4'h1);
        press(4'hC);
        press(4'h2);
        idle(1);
        obs_q.delete();
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h3;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({ld_a, ld_b, ld_m, state, op_sub, disp_sel} !== 7'b0) begin
            bad++;
            $display("FAIL midreset_during: got %b required 0", {ld_a, ld_b, ld_m, state, op_sub, disp_sel});
        end
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
        idle(3);
        total++;
        if (obs_q.size() !== 0) begin
            bad++; $display("FAIL midreset_pulses: got %0d required 0", obs_q.size());
        end
        total++;
        if ({state, op_sub, disp_sel} !== 4'b0) begin
            bad++; $display("FAIL midreset_state: got %b required 0000", {state, op_sub, disp_sel});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digit_limit();
        test_repeat_eq();
        test_memory();
        test_chain();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
